// File: rtl/pc_predict_unit.sv
// Fetch-address generator: registered pc plus a tagged BTB with saturating direction counters.
// Define PC_PREDICT_BTB_EN to build the tables; without it only redirect/stall/sequential fetch remain.
module pc_predict_unit #(
  parameter int          ENTRIES  = 128,
  parameter int          TAG_BITS = 9,
  parameter int          CNT_BITS = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        jump_flag,
  input  logic        branch_flag,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic [31:0] branch_to,
  input  logic [4:0]  stall_signal
);

  // Redirect contract: jump_flag in cycle N puts branch_to on pc in N+1,
  // ahead of stall and prediction; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (jump_flag) begin
      pc <= branch_to;
    end else if (!stall_signal[0]) begin
      pc <= pred_taken ? pred_target : pc + 32'd4;
    end
  end

`ifdef PC_PREDICT_BTB_EN
  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

  logic [IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0] wr_idx;
  logic [TAG_BITS-1:0] rd_tag;
  logic [TAG_BITS-1:0] wr_tag;
  logic                rd_hit;
  logic                wr_hit;
  logic [CNT_BITS-1:0] cnt_next;
  logic                unused_ok;

  assign rd_idx = pc[IDX_BITS+1:2];
  assign rd_tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign wr_idx = branch_pc[IDX_BITS+1:2];
  assign wr_tag = branch_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign wr_hit      = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  assign pred_taken  = rd_hit && cnt_q[rd_idx][CNT_BITS-1];
  assign pred_target = target_q[rd_idx];

  // A miss allocates with the counter just across the taken/not-taken boundary.
  always_comb begin
    cnt_next = branch_taken ? CNT_WT : CNT_WNT;
    if (wr_hit) begin
      if (branch_taken) begin
        cnt_next = (cnt_q[wr_idx] == CNT_MAX) ? CNT_MAX : cnt_q[wr_idx] + CNT_BITS'(1);
      end else begin
        cnt_next = (cnt_q[wr_idx] == '0) ? '0 : cnt_q[wr_idx] - CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_WNT;
      end
    end else if (branch_flag) begin
      valid_q[wr_idx] <= 1'b1;
      cnt_q[wr_idx]   <= cnt_next;
    end
  end

  // Tag and target carry no reset; valid_q guards them.
  always_ff @(posedge clk) begin
    if (branch_flag && !rst) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= branch_to;
    end
  end

  assign unused_ok = ^{branch_pc, stall_signal[4:1]};
`else
  logic unused_ok;

  assign pred_taken  = 1'b0;
  assign pred_target = 32'h0;
  assign unused_ok   = ^{branch_flag, branch_taken, branch_pc, stall_signal[4:1]};
`endif

endmodule

// File: tb/tb_pc_predict_unit.sv
// Bench for pc_predict_unit: directed scenarios with literal expectations, then random traffic
// against a table model; honours PC_PREDICT_BTB_EN the same way the design does.
module tb_pc_predict_unit;
  localparam int          ENTRIES  = 128;
  localparam int          TAG_BITS = 9;
  localparam int          CNT_BITS = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          IDX_BITS = $clog2(ENTRIES);
`ifdef PC_PREDICT_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        jump_flag = 1'b0;
  logic        branch_flag = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_pc = '0;
  logic [31:0] branch_to = '0;
  logic [4:0]  stall_signal = '0;

  int checks = 0;
  int errors = 0;

  pc_predict_unit #(
    .ENTRIES(ENTRIES), .TAG_BITS(TAG_BITS), .CNT_BITS(CNT_BITS), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .jump_flag(jump_flag), .branch_flag(branch_flag), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .branch_to(branch_to), .stall_signal(stall_signal)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural model: plain arrays indexed by address arithmetic
  bit          model_ok = 1'b0;
  int unsigned m_pc;
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_cnt   [ENTRIES];

  function automatic int unsigned idx_of(input int unsigned a);
    return (a / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input int unsigned a);
    return (a / (4 * ENTRIES)) % (2 ** TAG_BITS);
  endfunction

  function automatic bit m_hit(input int unsigned a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  function automatic bit m_pred(input int unsigned a);
    return BTB && m_hit(a) && (m_cnt[idx_of(a)] >= 2 ** (CNT_BITS - 1));
  endfunction

  function automatic int unsigned m_next_pc();
    if (jump_flag) return branch_to;
    if (stall_signal[0]) return m_pc;
    if (m_pred(m_pc)) return m_tgt[idx_of(m_pc)];
    return m_pc + 32'd4;
  endfunction

  function automatic int m_new_cnt();
    int c;
    if (!m_hit(branch_pc)) return branch_taken ? 2 ** (CNT_BITS - 1) : 2 ** (CNT_BITS - 1) - 1;
    c = m_cnt[idx_of(branch_pc)];
    if (branch_taken) return (c == 2 ** CNT_BITS - 1) ? c : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_ok <= 1'b1;
      m_pc     <= RESET_PC;
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i] <= 1'b0;
        m_cnt[i]   <= 2 ** (CNT_BITS - 1) - 1;
      end
    end else begin
      m_pc <= m_next_pc();
      if (BTB && branch_flag) begin
        m_valid[idx_of(branch_pc)] <= 1'b1;
        m_tag[idx_of(branch_pc)]   <= tag_of(branch_pc);
        m_tgt[idx_of(branch_pc)]   <= branch_to;
        m_cnt[idx_of(branch_pc)]   <= m_new_cnt();
      end
    end
  end

  // scoreboard: expected queue filled by directed scenarios, drained by literal checks
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // every-cycle compare against the model, on the falling edge
  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_pc", pc, m_pc);
      chk("model_pred_taken", {31'b0, pred_taken}, {31'b0, m_pred(m_pc)});
      if (m_pred(m_pc) || !BTB)
        chk("model_pred_target", pred_target, BTB ? m_tgt[idx_of(m_pc)] : 32'h0);
    end
  end

  // driver: inputs applied just after a rising edge, held for one cycle, then cleared
  task automatic cyc(input logic r, input logic jf, input logic bf, input logic bt,
                     input logic [31:0] bpc, input logic [31:0] bto, input logic st);
    rst = r; jump_flag = jf; branch_flag = bf; branch_taken = bt;
    branch_pc = bpc; branch_to = bto; stall_signal = {4'b0, st};
    @(posedge clk); #1;
    rst = 1'b0; jump_flag = 1'b0; branch_flag = 1'b0; branch_taken = 1'b0;
    stall_signal = '0;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic jump(input logic [31:0] a);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, a, 1'b0);
  endtask

  task automatic train(input logic [31:0] a, input logic [31:0] t, input logic tk);
    cyc(1'b0, 1'b0, 1'b1, tk, a, t, 1'b0);
  endtask

  task automatic chk_pc(input string name);
    chk(name, pc, exp_q.pop_front());
  endtask

  function automatic logic [31:0] pool_addr();
    return (32'($urandom_range(0, 3)) << (IDX_BITS + 2)) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    @(posedge clk); #1;
    // reset and free-run
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    exp_q.push_back(32'h0); chk_pc("reset_pc");
    chk("reset_pred", {31'b0, pred_taken}, 32'h0);
    for (int i = 1; i < 4; i++) begin
      idle();
      exp_q.push_back(32'(4 * i)); chk_pc("free_run_pc");
      chk("free_run_pred", {31'b0, pred_taken}, 32'h0);
    end

    // train taken at 0x40, then fetch from it
    train(32'h40, 32'h10, 1'b1);
    jump(32'h40);
    chk("trained_pred", {31'b0, pred_taken}, {31'b0, BTB});
    chk("trained_target", pred_target, BTB ? 32'h10 : 32'h0);
    idle(); exp_q.push_back(BTB ? 32'h10 : 32'h44); chk_pc("trained_next");
    train(32'h40, 32'h10, 1'b0);
    jump(32'h40); idle(); exp_q.push_back(32'h44); chk_pc("weak_nt_next");

    // saturation
    for (int i = 0; i < 5; i++) train(32'h40, 32'h10, 1'b1);
    train(32'h40, 32'h10, 1'b0);
    jump(32'h40); idle(); exp_q.push_back(BTB ? 32'h10 : 32'h44); chk_pc("sat_one_nt");
    train(32'h40, 32'h10, 1'b0);
    jump(32'h40); idle(); exp_q.push_back(32'h44); chk_pc("sat_two_nt");

    // alias: same index, different tag
    train(32'h40, 32'h10, 1'b1); train(32'h40, 32'h10, 1'b1);
    jump(32'h240);
    chk("alias_pred", {31'b0, pred_taken}, 32'h0);
    idle(); exp_q.push_back(32'h244); chk_pc("alias_next");
    train(32'h240, 32'h80, 1'b1);
    jump(32'h40);
    chk("evicted_pred", {31'b0, pred_taken}, 32'h0);
    idle(); exp_q.push_back(32'h44); chk_pc("evicted_next");
    jump(32'h240);
    chk("alias_alloc_target", pred_target, BTB ? 32'h80 : 32'h0);

    // priority: jump over stall and prediction, stall hold, reset over jump
    train(32'h40, 32'h10, 1'b1);
    jump(32'h40);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h100, 1'b1);
    exp_q.push_back(32'h100); chk_pc("jump_over_stall");
    jump(32'h40);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      exp_q.push_back(32'h40); chk_pc("stall_hold");
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h100, 1'b1);
    exp_q.push_back(RESET_PC); chk_pc("reset_over_jump");
    chk("reset_clears_pred", {31'b0, pred_taken}, 32'h0);

    // random traffic, checked every cycle by the model compare
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 1)),
          pool_addr() | 32'($urandom_range(0, 3)),
          pool_addr(),
          ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
